// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM state type and op decode helpers for muldiv
package muldiv_pkg;

    localparam logic [1:0] MULDIV_OP_MULT  = 2'b00;
    localparam logic [1:0] MULDIV_OP_MULTU = 2'b01;
    localparam logic [1:0] MULDIV_OP_DIV   = 2'b10;
    localparam logic [1:0] MULDIV_OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        SIGN = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MULDIV_OP_DIV) || (op == MULDIV_OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MULDIV_OP_MULT) || (op == MULDIV_OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// rtl/muldiv_div_core.sv - radix-2 restoring divider on unsigned magnitudes, one quotient bit per step
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   rem_shift;
    logic             fits;
    logic [WIDTH-1:0] rem_sub;

    // The difference always fits in WIDTH bits when the divisor fits, so the top bit can be dropped.
    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        fits      = rem_shift >= {1'b0, dvsr};
        rem_sub   = rem_shift[WIDTH-1:0] - dvsr;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem   <= '0;
            quo   <= '0;
            dvsr  <= '0;
            count <= '0;
        end else if (load) begin
            rem   <= '0;
            quo   <= dividend;
            dvsr  <= divisor;
            count <= '0;
        end else if (step) begin
            rem   <= fits ? rem_sub : rem_shift[WIDTH-1:0];
            quo   <= {quo[WIDTH-2:0], fits};
            count <= count + 1'b1;
        end
    end

    assign quotient  = quo;
    assign remainder = rem;
    assign last      = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative multiply/divide unit with sign fix-up; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 flush,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    logic [1:0]         op_q;
    logic               neg_prod;
    logic               neg_quo;
    logic               neg_rem;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0]   mul_cnt;

    logic               is_signed;
    logic               is_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;
    logic               div_last;
    logic               div_load;
    logic [2*WIDTH-1:0] fixed;

    // Magnitudes of the most-negative value come out as 2^(WIDTH-1), which is exact when read unsigned.
    always_comb begin
        is_signed = op_is_signed(op);
        is_div    = op_is_div(op);
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        mag_a     = a_neg ? -a : a;
        mag_b     = b_neg ? -b : b;
        div_load  = (state == IDLE) & start & ~flush & is_div & (b != '0);
    end

    // Shift-add: multiplier sits in the low half of prod and drains out as the product fills in.
    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        mul_next = {mul_sum, prod[WIDTH-1:1]};
    end

    always_comb begin
        if (op_is_div(op_q)) begin
            fixed = {(neg_rem ? -div_rem : div_rem), (neg_quo ? -div_quo : div_quo)};
        end else begin
            fixed = neg_prod ? -prod : prod;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] fast_prod;

    // Sign-extended operands give the right low 2*WIDTH bits for both signed and unsigned products.
    always_comb begin
        a_ext     = {{WIDTH{a_neg}}, a};
        b_ext     = {{WIDTH{b_neg}}, b};
        fast_prod = a_ext * b_ext;
    end
`endif

    div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk       (clk),
        .resetn    (resetn),
        .load      (div_load),
        .step      (state == DIV),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            busy        <= 1'b0;
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
            result      <= '0;
            op_q        <= MULDIV_OP_MULT;
            neg_prod    <= 1'b0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            mcand       <= '0;
            prod        <= '0;
            mul_cnt     <= '0;
        end else if (flush) begin
            state       <= IDLE;
            busy        <= 1'b0;
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready       <= 1'b0;
                    div_by_zero <= 1'b0;
                    if (start) begin
                        op_q     <= op;
                        neg_prod <= a_neg ^ b_neg;
                        neg_quo  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        mcand    <= mag_a;
                        prod     <= {{WIDTH{1'b0}}, mag_b};
                        mul_cnt  <= '0;
                        busy     <= 1'b1;
                        if (is_div) begin
                            if (b == '0) begin
                                state       <= DONE;
                                result      <= {a, {WIDTH{1'b1}}};
                                ready       <= 1'b1;
                                div_by_zero <= 1'b1;
                            end else begin
                                state <= DIV;
                            end
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            state  <= DONE;
                            result <= fast_prod;
                            ready  <= 1'b1;
`else
                            state  <= MUL;
`endif
                        end
                    end
                end
                MUL: begin
                    prod    <= mul_next;
                    mul_cnt <= mul_cnt + 1'b1;
                    if (mul_cnt == CNT_W'(WIDTH - 1)) begin
                        state <= SIGN;
                    end
                end
                DIV: begin
                    if (div_last) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    result <= fixed;
                    ready  <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    ready       <= 1'b0;
                    div_by_zero <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - randomized self-checking bench for muldiv against an arithmetic reference model
module tb_muldiv;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 2;
`endif
    localparam int DIV_LAT = W + 2;
    localparam int BUDGET  = 200;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           start = 1'b0;
    logic           flush = 1'b0;
    logic [1:0]     op = 2'b00;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           ready;
    logic           div_by_zero;
    logic [2*W-1:0] result;

    int n_cmp = 0;
    int n_fail = 0;

    muldiv #(.WIDTH(W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .ready       (ready),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sp;
        longint sq;
        longint sr;
        logic [63:0] up;
        case (o)
            2'b00: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return sp;
            end
            2'b01: begin
                up = {32'd0, x} * {32'd0, y};
                return up;
            end
            2'b10: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                sq = longint'($signed(x)) / longint'($signed(y));
                sr = longint'($signed(x)) % longint'($signed(y));
                return {sr[31:0], sq[31:0]};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [W-1:0] y);
        if (o[1] && y == 0) return 1;
        if (o[1]) return DIV_LAT;
        return MUL_LAT;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Drives one operation and reports what the DUT showed; lat = -1 if ready never came.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [2*W-1:0] res, output logic dbz, output int lat,
                         output logic rdy_after);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!ready && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ready) lat = -1;
        res = result;
        dbz = div_by_zero;
        @(posedge clk); #1;
        rdy_after = ready;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, ready, div_by_zero} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 000", {busy, ready, div_by_zero});
        end
        n_cmp++;
        if (result !== '0) begin
            n_fail++;
            $display("FAIL reset_result got %h want 0", result);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_directed();
        logic [2*W-1:0] res;
        logic dbz, ra;
        int lat;
`ifdef MULDIV_FAST_MUL_EN
        do_op(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, res, dbz, lat, ra);
        n_cmp++;
        if (res !== 64'd6 || lat !== 1) begin
            n_fail++;
            $display("FAIL fast_mult got %h lat %0d want 6 lat 1", res, lat);
        end
`endif
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, res, dbz, lat, ra);
        n_cmp++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFEB || lat !== MUL_LAT) begin
            n_fail++;
            $display("FAIL mult_neg got %h lat %0d want ffffffffffffffeb lat %0d", res, lat, MUL_LAT);
        end
        do_op(2'b11, 32'd100, 32'd7, res, dbz, lat, ra);
        n_cmp++;
        if (res !== {32'd2, 32'd14} || dbz !== 1'b0 || lat !== DIV_LAT) begin
            n_fail++;
            $display("FAIL divu_100_7 got %h dbz %b lat %0d want 000000020000000e dbz 0 lat %0d", res, dbz, lat, DIV_LAT);
        end
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, res, dbz, lat, ra);
        n_cmp++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_m7_2 got %h want fffffffffffffffd", res);
        end
        do_op(2'b10, 32'd5, 32'd0, res, dbz, lat, ra);
        n_cmp++;
        if (res !== {32'd5, 32'hFFFF_FFFF} || dbz !== 1'b1 || lat !== 1 || ra !== 1'b0) begin
            n_fail++;
            $display("FAIL div_by_zero got %h dbz %b lat %0d ready_after %b want 00000005ffffffff dbz 1 lat 1 ready_after 0",
                     res, dbz, lat, ra);
        end
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, res, dbz, lat, ra);
        n_cmp++;
        if (res !== {32'd0, 32'h8000_0000} || dbz !== 1'b0) begin
            n_fail++;
            $display("FAIL div_overflow got %h dbz %b want 0000000080000000 dbz 0", res, dbz);
        end
    endtask

    task automatic test_random();
        logic [2*W-1:0] res;
        logic dbz, ra;
        int lat;
        logic [1:0] o;
        logic [W-1:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pick();
            y = pick();
            do_op(o, x, y, res, dbz, lat, ra);
            n_cmp++;
            if (res !== ref_result(o, x, y)) begin
                n_fail++;
                $display("FAIL rand_result op %0d a %h b %h got %h want %h", o, x, y, res, ref_result(o, x, y));
            end
            n_cmp++;
            if (dbz !== (o[1] && y == 0) || lat !== ref_latency(o, y) || ra !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_timing op %0d b %h got dbz %b lat %0d ready_after %b want dbz %b lat %0d ready_after 0",
                         o, y, dbz, lat, ra, (o[1] && y == 0), ref_latency(o, y));
            end
        end
    endtask

    task automatic test_flush();
        logic [2*W-1:0] res;
        logic dbz, ra;
        int lat;
        int seen;
        do_op(2'b01, 32'd5, 32'd6, res, dbz, lat, ra);
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = $urandom; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || ready !== 1'b0 || result !== 64'd30) begin
            n_fail++;
            $display("FAIL flush_mid got busy %b ready %b result %h want busy 0 ready 0 result 1e", busy, ready, result);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL flush_no_ready got %0d pulses want 0", seen);
        end
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_priority got busy %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] res;
        logic dbz, ra;
        int lat;
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = $urandom; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || ready !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("FAIL reset_mid got busy %b ready %b result %h want busy 0 ready 0 result 0", busy, ready, result);
        end
        @(negedge clk);
        resetn = 1'b1;
        do_op(2'b01, 32'd3, 32'd4, res, dbz, lat, ra);
        n_cmp++;
        if (res !== 64'd12 || lat !== MUL_LAT) begin
            n_fail++;
            $display("FAIL multu_after_reset got %h lat %0d want c lat %0d", res, lat, MUL_LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] res;
        logic dbz, ra;
        int lat;
        logic [1:0] o;
        logic [W-1:0] x, y;
        for (int i = 0; i < 6; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom_range(1, 1000);
            do_op(o, x, y, res, dbz, lat, ra);
            n_cmp++;
            if (res !== ref_result(o, x, y) || lat !== ref_latency(o, y)) begin
                n_fail++;
                $display("FAIL back_to_back op %0d got %h lat %0d want %h lat %0d", o, res, lat, ref_result(o, x, y), ref_latency(o, y));
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        repeat (3) begin
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        while (!ready && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        n_cmp++;
        if (result !== {32'd1, 32'd333} || lat !== DIV_LAT) begin
            n_fail++;
            $display("FAIL busy_ignore got %h lat %0d want 000000010000014d lat %0d", result, lat, DIV_LAT);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_done got busy %b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_busy_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits (legal values 8..64, even).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request; sampled only in IDLE.
REQ-005 SHALL have port op, input, 2, operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports a and b, input, WIDTH each, operands; for division, a is the dividend and b is the divisor.
REQ-007 SHALL have port flush, input, 1, cancels any operation in flight.
REQ-008 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 SHALL have port ready, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port result, output, 2*WIDTH, {hi,lo}: the product for multiply, or {remainder,quotient} for divide.
REQ-011 SHALL have port div_by_zero, output, 1, valid while ready is high.

Function
REQ-012 SHALL use FSM states IDLE, MUL, DIV, SIGN and DONE.
REQ-013 SHALL latch a, b and op, and leave IDLE, only when start=1 and flush=0 in IDLE; start in any other state is ignored.
REQ-014 SHALL run iterative multiply as IDLE -> MUL (WIDTH cycles, shift-add on magnitudes) -> SIGN (1 cycle) -> DONE (1 cycle) -> IDLE.
REQ-015 SHALL run divide as IDLE -> DIV (WIDTH cycles, radix-2 restoring on magnitudes) -> SIGN -> DONE -> IDLE.
REQ-016 SHALL assert ready exactly WIDTH+2 cycles after the start-sampling edge, for both iterative multiply and divide.
REQ-017 SHALL give signed results as follows: product negated if a[msb]^b[msb]; quotient sign = a^b; remainder sign = sign of dividend.
REQ-018 SHALL, for DIV with most-negative / -1, produce quotient = most-negative (wrap) and remainder = 0, with no error flag.
REQ-019 SHALL, when b=0 for DIV/DIVU, skip the DIV state and go to DONE next cycle with lo = all ones, hi = a and div_by_zero = 1.
REQ-020 SHALL hold result stable from DONE until the next accepted start; ready and div_by_zero SHALL be 0 outside DONE.
REQ-021 SHALL, on flush=1 in any state, go to IDLE on the next edge with no ready pulse and result unchanged; flush has priority over start.
REQ-022 SHALL allow a new start in the cycle after DONE (back-to-back), with no idle gap beyond the return to IDLE.

Reset
REQ-023 SHALL, on resetn=0 at a clock edge, set state=IDLE, busy=0, ready=0, div_by_zero=0 and result=0, including mid-operation.
REQ-024 SHALL NOT register start in the first cycle after reset release unless resetn=1 at that edge.

Configuration
REQ-025 SHALL use macro MULDIV_FAST_MUL_EN; when it is defined, MULT/MULTU SHALL compute a single-cycle signed/unsigned product registered into result, giving IDLE -> DONE with ready 1 cycle after start.
REQ-026 SHALL, when MULDIV_FAST_MUL_EN is undefined, use the iterative MUL path of REQ-014; divide behaviour is identical in both builds.

Structure
REQ-027 SHALL place the op encodings (MULDIV_OP_*) and the FSM state encoding in shared package muldiv_pkg.
REQ-028 SHALL implement the restoring-divide datapath (partial remainder, quotient shift register, iteration counter) as sub-module div_core; sign fix-up and FSM stay in muldiv.

Verification (WIDTH=32, macro undefined unless stated)
REQ-029 SHALL cover MULT a=0xFFFFFFFD, b=7 -> ready at cycle 34, result=0xFFFFFFFF_FFFFFFEB.
REQ-030 SHALL cover DIVU a=100, b=7 -> hi=2, lo=14, div_by_zero=0; and DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 SHALL cover DIV a=5, b=0 -> ready 1 cycle after start, lo=0xFFFFFFFF, hi=5, div_by_zero=1.
REQ-032 SHALL cover DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 SHALL cover a flush pulse 10 cycles into a DIVU, and separately resetn=0 mid-DIV -> busy=0 next cycle, no ready, result unchanged after flush and 0 after reset; a following MULTU 3x4 -> result=12.
REQ-034 SHALL cover, with MULDIV_FAST_MUL_EN defined, MULT a=-2, b=-3 -> ready 1 cycle after start, result=6; start while busy is ignored.
